control_sequencer: RTL and testbench

Hardwired control unit for the Mini SRC datapath. It runs the three-step instruction fetch, decodes the opcode latched in IR, and steps through per-class execute states. In each state it drives the one-hot register/bus controls, memory strobes, ALU select and I/O port enables that the datapath consumes. It sits beside the datapath and replaces the hand-sequenced control of earlier benches.

---
 rtl/control_sequencer.sv | 179 +++++++++++++++++
 tb/tb_control_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: three-step fetch, opcode decode, per-class execute states.
// Optional macro CTRL_BRANCH_EN adds the conditional branch (opcode 10010); otherwise it decodes as nop.
module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
  output logic        PCout,
  output logic        IncPC,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLOin,
  output logic        R15in,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        read,
  output logic        write,
  output logic        RAMenable,
  output logic        conin,
  output logic        OutPortenable,
  output logic        PortInout,
  output logic [4:0]  aluControl,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_BR, C_JAL, C_JR, C_IN, C_OUT, C_HALT, C_NOP
  } op_class_t;

  state_t      state, next_state;
  op_class_t   op_class;
  logic [4:0]  opcode;
  logic [4:0]  imm_alu;
  logic        last_step;

  assign opcode = ir[31:27];

`ifdef CTRL_BRANCH_EN
  logic unused_bits;
  assign unused_bits = ^ir[26:0];
`else
  logic unused_bits;
  assign unused_bits = ^{ir[26:0], con};
`endif

  always_comb begin
    op_class = C_NOP;
    imm_alu  = ALU_ADD;
    case (opcode)
      5'b00000: op_class = C_LD;
      5'b00001: op_class = C_LDI;
      5'b00010: op_class = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: op_class = C_ALU;
      5'b01100: begin op_class = C_IMM; imm_alu = 5'b00011; end
      5'b01101: begin op_class = C_IMM; imm_alu = 5'b00101; end
      5'b01110: begin op_class = C_IMM; imm_alu = 5'b00110; end
`ifdef CTRL_BRANCH_EN
      5'b10010: op_class = C_BR;
`endif
      5'b10011: op_class = C_JAL;
      5'b10100: op_class = C_JR;
      5'b10110: op_class = C_IN;
      5'b10111: op_class = C_OUT;
      5'b11011: op_class = C_HALT;
      default:  op_class = C_NOP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) state <= S_RESET;
    else        state <= next_state;
  end

  always_comb begin
    PCout = 1'b0; IncPC = 1'b0; ZLOout = 1'b0; ZHIout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; ZLOin = 1'b0; R15in = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    read = 1'b0; write = 1'b0; RAMenable = 1'b0;
    conin = 1'b0; OutPortenable = 1'b0; PortInout = 1'b0;
    aluControl = 5'b00000;
    last_step  = 1'b0;
    next_state = state;

    case (state)
      S_RESET: next_state = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        ZLOout = 1'b1; PCin = 1'b1; read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1;
        next_state = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        next_state = S_T4;
        case (op_class)
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_BR:              begin Gra = 1'b1; Rout = 1'b1; conin = 1'b1; end
          C_JAL:             begin PCout = 1'b1; R15in = 1'b1; end
          C_JR:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; last_step = 1'b1; end
          C_IN:  begin PortInout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          C_OUT: begin Gra = 1'b1; Rout = 1'b1; OutPortenable = 1'b1; last_step = 1'b1; end
          C_HALT: next_state = S_HALT;
          default: last_step = 1'b1;
        endcase
      end
      S_T4: begin
        next_state = S_T5;
        case (op_class)
          C_LD, C_LDI, C_ST: begin Cout = 1'b1; ZLOin = 1'b1; aluControl = ALU_ADD; end
          C_ALU: begin Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; aluControl = opcode; end
          C_IMM: begin Cout = 1'b1; ZLOin = 1'b1; aluControl = imm_alu; end
          C_BR:  begin PCout = 1'b1; Yin = 1'b1; end
          C_JAL: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; last_step = 1'b1; end
          default: last_step = 1'b1;
        endcase
      end
      S_T5: begin
        next_state = S_T6;
        case (op_class)
          C_LD, C_ST: begin ZLOout = 1'b1; MARin = 1'b1; end
          C_LDI, C_ALU, C_IMM: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          C_BR: begin Cout = 1'b1; ZLOin = 1'b1; aluControl = ALU_ADD; end
          default: last_step = 1'b1;
        endcase
      end
      S_T6: begin
        next_state = S_T7;
        case (op_class)
          C_LD: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
          C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          // con only matters here; a not-taken branch simply ends with no controls
          C_BR: begin
            ZLOout = con; PCin = con; last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      S_T7: begin
        last_step = 1'b1;
        case (op_class)
          C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST: begin write = 1'b1; RAMenable = 1'b1; end
          default: ;
        endcase
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_RESET;
    endcase

    if (last_step) next_state = stop ? S_HALT : S_T0;
    run = (state != S_RESET) && (state != S_HALT);
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed vector table, hand sequences for halt/clear,
// and random instructions checked against a per-instruction behavioural model.
module tb_control_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear, con, stop;
  logic [31:0] ir;
  logic PCout, IncPC, ZLOout, ZHIout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, ZLOin, R15in;
  logic Gra, Grb, Grc, Rin, Rout, BAout, read, write, RAMenable, conin, OutPortenable, PortInout;
  logic [4:0] aluControl;
  logic run;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .con(con), .stop(stop),
    .PCout(PCout), .IncPC(IncPC), .ZLOout(ZLOout), .ZHIout(ZHIout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .ZLOin(ZLOin), .R15in(R15in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .read(read), .write(write), .RAMenable(RAMenable),
    .conin(conin), .OutPortenable(OutPortenable), .PortInout(PortInout),
    .aluControl(aluControl), .run(run)
  );

  localparam logic [24:0] PCOUT  = 25'd1 << 0;
  localparam logic [24:0] INCPC  = 25'd1 << 1;
  localparam logic [24:0] ZLOOUT = 25'd1 << 2;
  localparam logic [24:0] MDROUT = 25'd1 << 4;
  localparam logic [24:0] COUT   = 25'd1 << 5;
  localparam logic [24:0] MARIN  = 25'd1 << 6;
  localparam logic [24:0] PCIN   = 25'd1 << 7;
  localparam logic [24:0] MDRIN  = 25'd1 << 8;
  localparam logic [24:0] IRIN   = 25'd1 << 9;
  localparam logic [24:0] YIN    = 25'd1 << 10;
  localparam logic [24:0] ZLOIN  = 25'd1 << 11;
  localparam logic [24:0] R15IN  = 25'd1 << 12;
  localparam logic [24:0] GRA    = 25'd1 << 13;
  localparam logic [24:0] GRB    = 25'd1 << 14;
  localparam logic [24:0] GRC    = 25'd1 << 15;
  localparam logic [24:0] RIN    = 25'd1 << 16;
  localparam logic [24:0] ROUT   = 25'd1 << 17;
  localparam logic [24:0] BAOUT  = 25'd1 << 18;
  localparam logic [24:0] READ   = 25'd1 << 19;
  localparam logic [24:0] WRITE  = 25'd1 << 20;
  localparam logic [24:0] RAMEN  = 25'd1 << 21;
  localparam logic [24:0] CONIN  = 25'd1 << 22;
  localparam logic [24:0] OUTEN  = 25'd1 << 23;
  localparam logic [24:0] PORTIN = 25'd1 << 24;

  localparam logic [24:0] F0 = PCOUT | MARIN | INCPC | ZLOIN;
  localparam logic [24:0] F1 = ZLOOUT | PCIN | READ | RAMEN | MDRIN;
  localparam logic [24:0] F2 = MDROUT | IRIN;

  logic [24:0] actMask;
  assign actMask = {PortInout, OutPortenable, conin, RAMenable, write, read, BAout, Rout, Rin,
                    Grc, Grb, Gra, R15in, ZLOin, Yin, IRin, MDRin, PCin, MARin, Cout, MDRout,
                    ZHIout, ZLOout, IncPC, PCout};

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [31:0] ir;
    logic        con;
    logic        stop;
    logic [24:0] mask;
    logic [4:0]  alu;
    logic        run;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic [31:0] i, logic s, logic [24:0] m, logic [4:0] a);
    vec_t v;
    v.ir = i; v.con = 1'b0; v.stop = s; v.mask = m; v.alu = a; v.run = 1'b1;
    return v;
  endfunction

  // Instruction length in cycles, fetch included.
  function automatic int instrLen(logic [4:0] op);
    if (op == 5'd0 || op == 5'd2) return 8;
    if (op == 5'd1 || (op >= 5'd3 && op <= 5'd14)) return 6;
`ifdef CTRL_BRANCH_EN
    if (op == 5'd18) return 7;
`endif
    if (op == 5'd19) return 5;
    return 4;
  endfunction

  // Expected controls for a given instruction at a given step (0 = T0).
  function automatic void modelStep(input logic [4:0] op, input int step, input logic conVal,
                                    output logic [24:0] m, output logic [4:0] a);
    int k;
    m = '0; a = 5'd0; k = step - 3;
    if (step == 0) m = F0;
    else if (step == 1) m = F1;
    else if (step == 2) m = F2;
    else if (op <= 5'd2) begin
      if (k == 0) m = GRB | BAOUT | YIN;
      else if (k == 1) begin m = COUT | ZLOIN; a = 5'd3; end
      else if (k == 2) m = (op == 5'd1) ? (ZLOOUT | GRA | RIN) : (ZLOOUT | MARIN);
      else if (k == 3) m = (op == 5'd0) ? (READ | RAMEN | MDRIN) : (GRA | ROUT | MDRIN);
      else if (k == 4) m = (op == 5'd0) ? (MDROUT | GRA | RIN) : (WRITE | RAMEN);
    end else if (op <= 5'd14) begin
      if (k == 0) m = GRB | ROUT | YIN;
      else if (k == 1 && op <= 5'd11) begin m = GRC | ROUT | ZLOIN; a = op; end
      else if (k == 1) begin
        m = COUT | ZLOIN;
        a = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
      end
      else if (k == 2) m = ZLOOUT | GRA | RIN;
    end
`ifdef CTRL_BRANCH_EN
    else if (op == 5'd18) begin
      if (k == 0) m = GRA | ROUT | CONIN;
      else if (k == 1) m = PCOUT | YIN;
      else if (k == 2) begin m = COUT | ZLOIN; a = 5'd3; end
      else if (k == 3) m = conVal ? (ZLOOUT | PCIN) : '0;
    end
`endif
    else if (op == 5'd19) m = (k == 0) ? (PCOUT | R15IN) : (GRA | ROUT | PCIN);
    else if (op == 5'd20) m = GRA | ROUT | PCIN;
    else if (op == 5'd22) m = PORTIN | GRA | RIN;
    else if (op == 5'd23) m = GRA | ROUT | OUTEN;
  endfunction

  task automatic applyStimulus(input logic [31:0] irVal, input logic conVal,
                               input logic stopVal, input logic clearVal);
    ir = irVal; con = conVal; stop = stopVal; clear = clearVal;
  endtask

  task automatic checkOutput(input string name, input logic [24:0] expMask,
                             input logic [4:0] expAlu, input logic expRun);
    assertCount++;
    if (actMask !== expMask || aluControl !== expAlu || run !== expRun) begin
      failCount++;
      $display("[TB] FAIL %s: got mask=%h alu=%b run=%b, expected mask=%h alu=%b run=%b",
               name, actMask, aluControl, run, expMask, expAlu, expRun);
    end
  endtask

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      applyStimulus(ir, 1'b0, 1'b0, 1'b0);
      #1;
      if (i > 0) checkOutput("reset hold", '0, 5'd0, 1'b0);
    end
    @(negedge clock);
    applyStimulus(ir, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("reset release", '0, 5'd0, 1'b0);
  endtask

  task automatic runInstr(input logic [31:0] irVal, input logic conVal, input logic stopEnd,
                          input logic randStop, output logic halted);
    logic [4:0]  op;
    logic [24:0] m;
    logic [4:0]  a;
    logic        s;
    int          len;
    op  = irVal[31:27];
    len = instrLen(op);
    for (int step = 0; step < len; step++) begin
      @(negedge clock);
      s = (step == len - 1) ? stopEnd : (randStop ? 1'($urandom_range(0, 1)) : 1'b0);
      applyStimulus(irVal, conVal, s, 1'b1);
      #1;
      modelStep(op, step, conVal, m, a);
      checkOutput($sformatf("op %b step %0d", op, step), m, a, 1'b1);
    end
    halted = stopEnd || (op == 5'b11011);
  endtask

  task automatic checkHalted(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      applyStimulus($urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      #1;
      checkOutput("halt hold", '0, 5'd0, 1'b0);
    end
  endtask

  initial begin
    logic        halted;
    logic [24:0] m;
    logic [4:0]  a;
    logic [4:0]  op;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);

    // ld R1,0x14(R0); sub; out; in; then the next fetch
    for (int i = 0; i < 8; i++) begin
      logic [24:0] ldMasks [8];
      ldMasks = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ZLOIN, ZLOOUT | MARIN,
                  READ | RAMEN | MDRIN, MDROUT | GRA | RIN};
      vecs.push_back(mkVec(32'h0080_0014, (i == 3), ldMasks[i], (i == 4) ? 5'b00011 : 5'b00000));
    end
    vecs.push_back(mkVec(32'h2000_0000, 1'b0, F0, 5'd0));
    vecs.push_back(mkVec(32'h2000_0000, 1'b0, F1, 5'd0));
    vecs.push_back(mkVec(32'h2000_0000, 1'b0, F2, 5'd0));
    vecs.push_back(mkVec(32'h2000_0000, 1'b0, GRB | ROUT | YIN, 5'd0));
    vecs.push_back(mkVec(32'h2000_0000, 1'b0, GRC | ROUT | ZLOIN, 5'b00100));
    vecs.push_back(mkVec(32'h2000_0000, 1'b0, ZLOOUT | GRA | RIN, 5'd0));
    vecs.push_back(mkVec(32'hB800_0000, 1'b0, F0, 5'd0));
    vecs.push_back(mkVec(32'hB800_0000, 1'b0, F1, 5'd0));
    vecs.push_back(mkVec(32'hB800_0000, 1'b0, F2, 5'd0));
    vecs.push_back(mkVec(32'hB800_0000, 1'b0, GRA | ROUT | OUTEN, 5'd0));
    vecs.push_back(mkVec(32'hB000_0000, 1'b0, F0, 5'd0));
    vecs.push_back(mkVec(32'hB000_0000, 1'b0, F1, 5'd0));
    vecs.push_back(mkVec(32'hB000_0000, 1'b0, F2, 5'd0));
    vecs.push_back(mkVec(32'hB000_0000, 1'b0, PORTIN | GRA | RIN, 5'd0));
    vecs.push_back(mkVec(32'h0000_0000, 1'b0, F0, 5'd0));

    doReset(2);
    foreach (vecs[i]) begin
      @(negedge clock);
      applyStimulus(vecs[i].ir, vecs[i].con, vecs[i].stop, 1'b1);
      #1;
      checkOutput($sformatf("vector %0d", i), vecs[i].mask, vecs[i].alu, vecs[i].run);
    end

    // stop during add T5 halts; HALT holds with outputs low
    doReset(1);
    runInstr(32'h1800_0000, 1'b0, 1'b1, 1'b0, halted);
    checkHalted(10);

    // halt opcode
    doReset(1);
    runInstr(32'hD800_0000, 1'b0, 1'b0, 1'b1, halted);
    checkHalted(3);

    // clear asserted during ld T5 abandons the load
    doReset(1);
    for (int step = 0; step < 6; step++) begin
      @(negedge clock);
      applyStimulus(32'h0080_0014, 1'b0, 1'b0, (step != 5));
      #1;
      modelStep(5'd0, step, 1'b0, m, a);
      checkOutput($sformatf("ld before clear step %0d", step), m, a, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      applyStimulus(32'h0080_0014, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("abandoned ld", '0, 5'd0, 1'b0);
    end
    @(negedge clock);
    applyStimulus(32'h0080_0014, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("reset release after abort", '0, 5'd0, 1'b0);
    runInstr(32'h9880_0000, 1'b0, 1'b0, 1'b0, halted);

    // branch taken and not taken (nop timing when the branch is not built)
    runInstr(32'h9000_0000, 1'b1, 1'b0, 1'b1, halted);
    runInstr(32'h9000_0000, 1'b0, 1'b0, 1'b1, halted);
    runInstr(32'hA000_0000, 1'b0, 1'b0, 1'b0, halted);

    // random instruction stream
    for (int n = 0; n < 200; n++) begin
      op = 5'($urandom_range(0, 31));
      runInstr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
               1'b1, halted);
      if (halted) begin
        checkHalted(2);
        doReset(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
